wb_stage: RTL
=============

Name: wb_stage

Overview:
- Writeback stage; sits directly after the data-memory stage and consumes its registered outputs (load data, base-writeback data, ALU result, instruction, condition, load/store flag).
- Has one register-file write port.
- Turns each retiring instruction into zero, one or two register-file writes.
- Serialises the second write of a load with base writeback, stalling upstream for one cycle.

Parameters:
- DW, 16, data/register width.
- RA, 4, register address width (16 architectural registers, R15 = PC).

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-high reset
- valid_in  input  1  upstream presents an instruction this cycle
- condition_in  input  1  instruction's condition passed
- LS_in  input  1  instruction is a load/store
- instruction_in  input  32  instruction word; [24:21] opcode (DP), [21] W, [20] L, [19:16] rn, [15:12] rd
- mem_data  input  DW  loaded data (rd value)
- base_wb  input  DW  updated base address (rn value)
- alu_in  input  DW  data-processing result
- stall  output  1  upstream must hold all inputs this cycle
- rf_we  output  1  register-file write enable
- rf_waddr  output  RA  write address
- rf_wdata  output  DW  write data
- pc_load  output  1  pulses with rf_we when rf_waddr == 15

Behaviour:
- Acceptance:
  - An instruction is accepted on a rising edge with valid_in=1 and stall=0.
  - All outputs are registered; the first write appears the cycle after acceptance.
- Reset (async): state=IDLE; stall, rf_we and pc_load = 0; rf_waddr and rf_wdata = 0; pending registers cleared.
- Write decode on acceptance:
  - condition_in=0: no write, state stays IDLE.
  - LS_in=0, opcode 1000/1001/1010/1011 (TST/TEQ/CMP/CMN): no write.
  - LS_in=0, any other opcode: write rd <= alu_in.
  - LS_in=1, L=1: write rd <= mem_data. If W=1 and rn!=15 and rn!=rd, latch rn/base_wb as pending and go to WB_RN.
  - LS_in=1, L=1, rn==rd: load data wins; base write dropped; no stall.
  - LS_in=1, L=0 (store): if W=1 and rn!=15, write rn <= base_wb; else no write.
- W handling: W is treated as 0 whenever rn==15.
- States:
  - IDLE: stall=0.
  - WB_RN: stall=1 for exactly one cycle. The cycle after, rf_we writes the pending rn/base_wb. Returns to IDLE next edge; inputs are ignored while in this state.
- Pulse widths: rf_we and pc_load are single-cycle pulses per write; back-to-back accepted instructions produce back-to-back writes.
- Idle values: rf_waddr and rf_wdata hold their last values when rf_we=0.
- Reset mid-operation: a reset asserted in WB_RN discards the pending write; stall deasserts immediately (asynchronously).
- valid_in=0: no write and no state change (except WB_RN completion).

Optional Feature:
- Macro: WB_PERF_CNT_EN.
- When defined, adds outputs retire_cnt[31:0] and rf_write_cnt[31:0]:
  - retire_cnt increments on each accepted instruction with condition_in=1.
  - rf_write_cnt increments on each cycle rf_we=1.
  - Both counters wrap at 2^32 and clear on reset.
- When undefined, neither port nor counter logic exists; all other behaviour is identical.

Test Plan:
- ADD R6: accept DP opcode 0100, rd=6, alu_in=0x000D, cond=1 -> next cycle rf_we=1, waddr=6, wdata=0x000D; stall never asserted.
- CMP suppression: opcode 1010, rd=1, alu_in=0xFFFF -> rf_we stays 0 for 3 cycles.
- LDR with writeback: L=1, W=1, rd=2, rn=3, mem_data=0x1234, base_wb=0x0010 -> cycle+1 write R2=0x1234 with stall=1; cycle+2 write R3=0x0010, stall=0; held inputs are not re-accepted.
- Condition fail and rn==rd: cond=0 load -> no write. Then L=1, W=1, rd=rn=4, mem_data=0x00AA -> single write R4=0x00AA, no stall.
- PC write and store: load rd=15, mem_data=0x0040 -> rf_we=1, pc_load=1, waddr=15. Store W=1, rn=5, base_wb=0x0008 -> write R5=0x0008. Store with rn=15, W=1 -> no write.
- Reset in WB_RN: assert reset during the stall cycle -> stall and rf_we drop immediately; pending R3 write never occurs. With WB_PERF_CNT_EN, both counters read 0 after reset.

Source files
------------

// File: rtl/wb_stage.sv
// Writeback stage: turns each retiring instruction into zero, one or two register-file writes.
// Optional performance counters are enabled with the WB_PERF_CNT_EN macro.
module wb_stage #(
  parameter int DW = 16,
  parameter int RA = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          valid_in,
  input  logic          condition_in,
  input  logic          LS_in,
  input  logic [31:0]   instruction_in,
  input  logic [DW-1:0] mem_data,
  input  logic [DW-1:0] base_wb,
  input  logic [DW-1:0] alu_in,
  output logic          stall,
  output logic          rf_we,
  output logic [RA-1:0] rf_waddr,
  output logic [DW-1:0] rf_wdata,
  output logic          pc_load
`ifdef WB_PERF_CNT_EN
  ,
  output logic [31:0]   retire_cnt,
  output logic [31:0]   rf_write_cnt
`endif
);

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    WB_RN = 1'b1
  } state_t;

  state_t        state_r, state_s;
  logic [RA-1:0] pend_addr_r, pend_addr_s;
  logic [DW-1:0] pend_data_r, pend_data_s;
  logic          we_s, stall_s, pc_load_s;
  logic [RA-1:0] waddr_s;
  logic [DW-1:0] wdata_s;

  logic [3:0]    opcode_s;
  logic          w_s, l_s, w_eff_s, accept_s;
  logic [RA-1:0] rn_s, rd_s;
  logic          unused_s;

  assign opcode_s = instruction_in[24:21];
  assign w_s      = instruction_in[21];
  assign l_s      = instruction_in[20];
  assign rn_s     = instruction_in[16 +: RA];
  assign rd_s     = instruction_in[12 +: RA];
  assign unused_s = ^{instruction_in[31:25], instruction_in[11:0]};
  // Base writeback to the PC is never honoured.
  assign w_eff_s  = w_s && (rn_s != {RA{1'b1}});
  assign accept_s = valid_in && !stall;

  // Write decode and next-state selection.
  always_comb begin
    state_s     = state_r;
    pend_addr_s = pend_addr_r;
    pend_data_s = pend_data_r;
    we_s        = 1'b0;
    stall_s     = 1'b0;
    waddr_s     = rf_waddr;
    wdata_s     = rf_wdata;
    case (state_r)
      IDLE: begin
        if (accept_s && condition_in) begin
          if (!LS_in) begin
            if (opcode_s[3:2] == 2'b10) begin
              we_s = 1'b0;
            end else begin
              we_s    = 1'b1;
              waddr_s = rd_s;
              wdata_s = alu_in;
            end
          end else if (l_s) begin
            we_s    = 1'b1;
            waddr_s = rd_s;
            wdata_s = mem_data;
            // rn==rd: the loaded value wins and the base update is dropped.
            if (w_eff_s && (rn_s != rd_s)) begin
              state_s     = WB_RN;
              stall_s     = 1'b1;
              pend_addr_s = rn_s;
              pend_data_s = base_wb;
            end else begin
              state_s = IDLE;
            end
          end else if (w_eff_s) begin
            we_s    = 1'b1;
            waddr_s = rn_s;
            wdata_s = base_wb;
          end else begin
            we_s = 1'b0;
          end
        end else begin
          state_s = IDLE;
        end
      end
      WB_RN: begin
        we_s    = 1'b1;
        waddr_s = pend_addr_r;
        wdata_s = pend_data_r;
        state_s = IDLE;
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  assign pc_load_s = we_s && (waddr_s == {RA{1'b1}});

  // State, pending write and registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r     <= IDLE;
      pend_addr_r <= {RA{1'b0}};
      pend_data_r <= {DW{1'b0}};
      stall       <= 1'b0;
      rf_we       <= 1'b0;
      rf_waddr    <= {RA{1'b0}};
      rf_wdata    <= {DW{1'b0}};
      pc_load     <= 1'b0;
    end else begin
      state_r     <= state_s;
      pend_addr_r <= pend_addr_s;
      pend_data_r <= pend_data_s;
      stall       <= stall_s;
      rf_we       <= we_s;
      rf_waddr    <= waddr_s;
      rf_wdata    <= wdata_s;
      pc_load     <= pc_load_s;
    end
  end

`ifdef WB_PERF_CNT_EN
  // Retired-instruction and register-write counters, wrapping at 2^32.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      retire_cnt   <= 32'd0;
      rf_write_cnt <= 32'd0;
    end else begin
      if (accept_s && condition_in) begin
        retire_cnt <= retire_cnt + 32'd1;
      end
      if (rf_we) begin
        rf_write_cnt <= rf_write_cnt + 32'd1;
      end
    end
  end
`endif

endmodule
